axi4_wr_arbiter: RTL and testbench
==================================

AXI4_WR_ARBITER -- requirements
Module: axi4_wr_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, AW address width.
REQ-002 Parameter DATA_WIDTH, default 32, W data width; wstrb width is DATA_WIDTH/8.
REQ-003 aclk  in  1  single clock; all logic on rising edge.
REQ-004 areset  in  1  synchronous, active-high reset.
REQ-005 mN_awvalid / mN_awready  in / out  1  master N (N=0,1) AW handshake.
REQ-006 mN_awid, mN_awlen  in  8 each  master N AW id and burst length.
REQ-007 mN_awaddr  in  ADDRESS_WIDTH  master N AW address.
REQ-008 mN_awsize / mN_awburst  in  3 / 2  master N AW size and burst type.
REQ-009 mN_wvalid / mN_wready  in / out  1  master N W handshake.
REQ-010 mN_wdata / mN_wstrb / mN_wlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  master N W payload.
REQ-011 mN_bvalid / mN_bready  out / in  1  master N B handshake.
REQ-012 mN_bid / mN_bresp  out  8 / 2  master N B payload.
REQ-013 s_aw* / s_w* / s_b*  mirror of REQ-005..012 with opposite directions  shared slave port.
REQ-014 grant  out  1  index of the currently or last granted master.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 err_wlast  out  1  sticky flag for a master wlast mismatch.

Function
REQ-017 The FSM SHALL have four states, IDLE, ADDR, DATA and RESP, and SHALL allow one outstanding transaction at a time.
REQ-018 In IDLE, if any mN_awvalid is high:
- Arbitration SHALL select one master by round-robin; with both requesting, the master other than last_grant wins.
- The winner SHALL be registered into grant.
- The FSM SHALL move to ADDR on the next edge.
REQ-019 In ADDR:
- s_awvalid SHALL equal the granted mN_awvalid.
- s_aw* fields SHALL carry the granted master's fields.
- The granted mN_awready SHALL equal s_awready.
- On an s_awvalid&&s_awready handshake, the FSM SHALL latch awlen, clear beat_cnt and move to DATA.
REQ-020 In DATA:
- s_wvalid, s_wdata and s_wstrb SHALL carry the granted master's signals.
- The granted mN_wready SHALL equal s_wready.
- beat_cnt (8 bit) SHALL increment on each W handshake.
REQ-021 s_wlast SHALL be driven as (beat_cnt == latched awlen), independent of mN_wlast.
REQ-022 On the W handshake where s_wlast=1, the FSM SHALL move to RESP.
REQ-023 On any W handshake where mN_wlast != s_wlast, err_wlast SHALL set and remain set until reset.
REQ-024 In RESP:
- s_bready SHALL equal the granted mN_bready.
- mN_bvalid, mN_bid and mN_bresp of the granted master SHALL carry the s_b* signals.
- On a B handshake, last_grant SHALL take grant and the FSM SHALL move to IDLE.
REQ-025 The non-granted master's awready, wready and bvalid SHALL be 0 in every state.
REQ-026 All slave-side valid and ready outputs SHALL be 0 in IDLE.
REQ-027 Latency SHALL be as follows:
- s_awvalid rises one cycle after mN_awvalid is sampled in IDLE.
- A fully ready transaction takes 1 (arb) + 1 (AW) + awlen+1 (W) + 1 (B) cycles.
- The next arbitration starts the cycle after the B handshake.
REQ-028 A request that arrives during a non-IDLE state SHALL wait without being dropped; awvalid is required to be held by the master.
REQ-029 awlen=0 SHALL produce a single beat with s_wlast=1; awlen=255 SHALL produce 256 beats, and beat_cnt SHALL not wrap before the last beat.
REQ-030 Response payloads SHALL pass through unmodified; arbitration SHALL NOT alter the ID.

Reset
REQ-031 On areset=1 at a clock edge, the block SHALL reset as follows:
- state=IDLE, grant=0, last_grant=1, beat_cnt=0, err_wlast=0.
- All valid and ready outputs = 0, busy=0.
- Payload outputs = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction; all handshake outputs SHALL be 0 from the following cycle.

Verification
REQ-033 Both masters assert awvalid in the same cycle after reset -> m0 granted first, then m1 after m0's B handshake.
REQ-034 m0 issues back-to-back bursts while m1 requests -> grants alternate m0, m1, m0.
REQ-035 m1 sends awlen=3 with wlast on beat 4 and s_*ready held high -> exactly 4 s_w handshakes, s_wlast on beat 4, RESP entered, 7 cycles from request to B, err_wlast=0.
REQ-036 m0 sends awlen=2 with wlast on beat 2 -> err_wlast=1 on beat 2, s_wlast on beat 3, err_wlast stays 1.
REQ-037 s_wready is toggled 1/0 during an awlen=7 burst -> beat_cnt advances only on handshakes and 8 beats are delivered in order.
REQ-038 areset is pulsed during DATA beat 2 -> next cycle busy=0 and all ready/valid=0; a fresh request is then granted normally.

Source files
------------

// File: rtl/axi4_wr_arbiter_if.sv
// One AXI4 write-channel bundle (AW, W, B). The master modport drives requests;
// the slave modport drives readies and responses.
interface axi4_wr_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [7:0]                awid;
    logic [7:0]                awlen;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awsize;
    logic [1:0]                awburst;

    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;

    logic                      bvalid;
    logic                      bready;
    logic [7:0]                bid;
    logic [1:0]                bresp;

    modport master (
        output awvalid, awid, awlen, awaddr, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bid, bresp
    );

    modport slave (
        input  awvalid, awid, awlen, awaddr, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Two-master round-robin AXI4 write arbiter onto one slave port.
// One transaction in flight; s_wlast is generated from the latched awlen.
module axi4_wr_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic              aclk,
    input  logic              areset,
    axi4_wr_arbiter_if.slave  m0,
    axi4_wr_arbiter_if.slave  m1,
    axi4_wr_arbiter_if.master s,
    output logic              grant,
    output logic              busy,
    output logic              err_wlast
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic [7:0] awlen_q;
    logic       pick;

    logic                     sel_awvalid;
    logic [7:0]               sel_awid;
    logic [7:0]               sel_awlen;
    logic [ADDRESS_WIDTH-1:0] sel_awaddr;
    logic [2:0]               sel_awsize;
    logic [1:0]               sel_awburst;
    logic                     sel_wvalid;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [DATA_WIDTH/8-1:0]  sel_wstrb;
    logic                     sel_wlast;
    logic                     sel_bready;

    logic aw_hs;
    logic w_hs;
    logic b_hs;

    // Round-robin: on a tie the master that did not go last wins.
    always_comb begin
        if (m0.awvalid && m1.awvalid) begin
            pick = ~last_grant;
        end else begin
            pick = m1.awvalid;
        end
    end

    always_comb begin
        sel_awvalid = m0.awvalid;
        sel_awid    = m0.awid;
        sel_awlen   = m0.awlen;
        sel_awaddr  = m0.awaddr;
        sel_awsize  = m0.awsize;
        sel_awburst = m0.awburst;
        sel_wvalid  = m0.wvalid;
        sel_wdata   = m0.wdata;
        sel_wstrb   = m0.wstrb;
        sel_wlast   = m0.wlast;
        sel_bready  = m0.bready;
        if (grant) begin
            sel_awvalid = m1.awvalid;
            sel_awid    = m1.awid;
            sel_awlen   = m1.awlen;
            sel_awaddr  = m1.awaddr;
            sel_awsize  = m1.awsize;
            sel_awburst = m1.awburst;
            sel_wvalid  = m1.wvalid;
            sel_wdata   = m1.wdata;
            sel_wstrb   = m1.wstrb;
            sel_wlast   = m1.wlast;
            sel_bready  = m1.bready;
        end
    end

    // Slave side: every field is forced to zero outside its own phase.
    always_comb begin
        s.awvalid = 1'b0;
        s.awid    = '0;
        s.awlen   = '0;
        s.awaddr  = '0;
        s.awsize  = '0;
        s.awburst = '0;
        s.wvalid  = 1'b0;
        s.wdata   = '0;
        s.wstrb   = '0;
        s.wlast   = 1'b0;
        s.bready  = 1'b0;
        unique case (state)
            ADDR: begin
                s.awvalid = sel_awvalid;
                s.awid    = sel_awid;
                s.awlen   = sel_awlen;
                s.awaddr  = sel_awaddr;
                s.awsize  = sel_awsize;
                s.awburst = sel_awburst;
            end
            DATA: begin
                s.wvalid = sel_wvalid;
                s.wdata  = sel_wdata;
                s.wstrb  = sel_wstrb;
                s.wlast  = (beat_cnt == awlen_q);
            end
            RESP: begin
                s.bready = sel_bready;
            end
            default: begin
            end
        endcase
    end

    // Master side: only the granted master ever sees a ready or a response.
    always_comb begin
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m0.bid     = '0;
        m0.bresp   = '0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bvalid  = 1'b0;
        m1.bid     = '0;
        m1.bresp   = '0;
        unique case (state)
            ADDR: begin
                if (grant) m1.awready = s.awready;
                else       m0.awready = s.awready;
            end
            DATA: begin
                if (grant) m1.wready = s.wready;
                else       m0.wready = s.wready;
            end
            RESP: begin
                if (grant) begin
                    m1.bvalid = s.bvalid;
                    m1.bid    = s.bid;
                    m1.bresp  = s.bresp;
                end else begin
                    m0.bvalid = s.bvalid;
                    m0.bid    = s.bid;
                    m0.bresp  = s.bresp;
                end
            end
            default: begin
            end
        endcase
    end

    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid && s.wready;
    assign b_hs  = s.bvalid && s.bready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= 8'd0;
            err_wlast  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.awvalid || m1.awvalid) begin
                        grant <= pick;
                        state <= ADDR;
                        busy  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        awlen_q  <= sel_awlen;
                        beat_cnt <= 8'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        // Wraps only on the 256th beat, which is also the one that leaves DATA.
                        beat_cnt <= beat_cnt + 8'd1;
                        if (sel_wlast != s.wlast) err_wlast <= 1'b1;
                        if (s.wlast) state <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        last_grant <= grant;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter: a vector table of single transactions
// plus hand-written sequences for tie arbitration, alternation and mid-burst reset.
module tb_axi4_wr_arbiter;

    logic aclk;
    logic areset;
    logic grant;
    logic busy;
    logic err_wlast;

    axi4_wr_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    axi4_wr_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    axi4_wr_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi4_wr_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .grant     (grant),
        .busy      (busy),
        .err_wlast (err_wlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit         mst;
        logic [7:0] id;
        logic [7:0] len;
        int         wlast_beat;
        bit         toggle;
        int         exp_cycles;
        int         exp_beats;
        int         exp_wlast_pos;
        int         exp_err_beat;
        bit         exp_err;
    } vec_t;

    vec_t vecs [6];

    int         r_cycles, r_beats, r_wlast_pos, r_err_beat;
    bit         r_pay_ok, r_iso_ok, r_grant, r_timeout;
    logic [7:0] r_bid;
    logic [1:0] r_bresp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] addr_of(input logic [7:0] id);
        return {16'h4000, id, 8'h00};
    endfunction

    function automatic logic [31:0] beat_data(input logic [7:0] id, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {id, kb, ~id, kb ^ 8'h5A};
    endfunction

    function automatic logic [3:0] beat_strb(input int k);
        return 4'(k) | 4'h1;
    endfunction

    function automatic bit iso_clean(input bit mst);
        if (mst) return !m0_if.awready && !m0_if.wready && !m0_if.bvalid;
        else     return !m1_if.awready && !m1_if.wready && !m1_if.bvalid;
    endfunction

    task automatic drive_aw(input bit mst, input bit v, input logic [7:0] id, input logic [7:0] len);
        if (mst) begin
            m1_if.awvalid = v; m1_if.awid = id; m1_if.awlen = len;
            m1_if.awaddr = addr_of(id); m1_if.awsize = 3'd2; m1_if.awburst = 2'b01;
        end else begin
            m0_if.awvalid = v; m0_if.awid = id; m0_if.awlen = len;
            m0_if.awaddr = addr_of(id); m0_if.awsize = 3'd2; m0_if.awburst = 2'b01;
        end
    endtask

    task automatic drive_w(input bit mst, input bit v, input logic [7:0] id, input int k, input bit last);
        if (mst) begin
            m1_if.wvalid = v; m1_if.wdata = beat_data(id, k); m1_if.wstrb = beat_strb(k); m1_if.wlast = last;
        end else begin
            m0_if.wvalid = v; m0_if.wdata = beat_data(id, k); m0_if.wstrb = beat_strb(k); m0_if.wlast = last;
        end
    endtask

    task automatic drive_b(input bit mst, input bit v);
        if (mst) m1_if.bready = v;
        else     m0_if.bready = v;
    endtask

    task automatic clear_inputs();
        drive_aw(1'b0, 1'b0, 8'h00, 8'h00);
        drive_aw(1'b1, 1'b0, 8'h00, 8'h00);
        drive_w(1'b0, 1'b0, 8'h00, 0, 1'b0);
        drive_w(1'b1, 1'b0, 8'h00, 0, 1'b0);
        drive_b(1'b0, 1'b0);
        drive_b(1'b1, 1'b0);
        s_if.awready = 1'b0; s_if.wready = 1'b0;
        s_if.bvalid = 1'b0; s_if.bid = 8'h00; s_if.bresp = 2'b00;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // One write from master mst with the slave always ready (wready optionally toggling).
    task automatic run_txn(input bit mst, input logic [7:0] id, input logic [7:0] len,
                           input int wlast_beat, input bit toggle,
                           output int cycles, output int beats, output int wlast_pos,
                           output int err_beat, output bit pay_ok, output bit iso_ok,
                           output bit got_grant, output logic [7:0] got_bid,
                           output logic [1:0] got_bresp, output bit timeout);
        int phase;
        bit awhs, whs, bhs, last_hs;
        logic [7:0] cap_id;
        cycles = 0; beats = 0; wlast_pos = 0; err_beat = 0; pay_ok = 1; iso_ok = 1;
        got_grant = 0; got_bid = 0; got_bresp = 0; timeout = 0; cap_id = 0; phase = 0;
        drive_aw(mst, 1'b1, id, len);
        drive_b(mst, 1'b1);
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        s_if.bvalid = 1'b0; s_if.bid = 8'h00; s_if.bresp = 2'b00;
        while (phase != 3) begin
            if (cycles >= 1000) begin
                timeout = 1;
                break;
            end
            @(negedge aclk);
            awhs    = s_if.awvalid && s_if.awready;
            whs     = s_if.wvalid && s_if.wready;
            bhs     = s_if.bvalid && s_if.bready;
            last_hs = whs && s_if.wlast;
            if (err_wlast && err_beat == 0) err_beat = beats;
            if (!iso_clean(mst)) iso_ok = 0;
            if (awhs) begin
                got_grant = grant;
                cap_id    = s_if.awid;
                if (s_if.awid !== id || s_if.awlen !== len || s_if.awaddr !== addr_of(id) ||
                    s_if.awsize !== 3'd2 || s_if.awburst !== 2'b01) pay_ok = 0;
            end
            if (whs) begin
                if (s_if.wdata !== beat_data(id, beats) || s_if.wstrb !== beat_strb(beats)) pay_ok = 0;
                beats++;
                if (s_if.wlast && wlast_pos == 0) wlast_pos = beats;
            end
            if (bhs) begin
                got_bid   = mst ? m1_if.bid : m0_if.bid;
                got_bresp = mst ? m1_if.bresp : m0_if.bresp;
                if (!(mst ? m1_if.bvalid : m0_if.bvalid)) pay_ok = 0;
            end
            @(posedge aclk);
            cycles++;
            #1;
            if (awhs) begin
                drive_aw(mst, 1'b0, id, len);
                drive_w(mst, 1'b1, id, 0, wlast_beat == 1);
                phase = 1;
            end
            if (whs) begin
                if (beats <= int'(len)) drive_w(mst, 1'b1, id, beats, wlast_beat == beats + 1);
                else                    drive_w(mst, 1'b0, id, 0, 1'b0);
            end
            if (last_hs) begin
                s_if.bvalid = 1'b1; s_if.bid = cap_id; s_if.bresp = cap_id[1:0];
                phase = 2;
            end
            if (bhs) begin
                s_if.bvalid = 1'b0; s_if.bid = 8'h00; s_if.bresp = 2'b00;
                drive_b(mst, 1'b0);
                phase = 3;
            end
            if (toggle) s_if.wready = !s_if.wready;
        end
    endtask

    initial begin
        areset = 1'b0;
        clear_inputs();

        //             mst   id     len     wl   tgl  cyc  beats wpos ebeat err
        vecs[0] = '{1'b0, 8'h11, 8'd0,   1,   1'b0, 4,   1,   1,   0,  1'b0};
        vecs[1] = '{1'b1, 8'hA5, 8'd3,   4,   1'b0, 7,   4,   4,   0,  1'b0};
        vecs[2] = '{1'b0, 8'h3C, 8'd2,   2,   1'b0, 6,   3,   3,   2,  1'b1};
        vecs[3] = '{1'b1, 8'h7E, 8'd7,   8,   1'b1, 18,  8,   8,   0,  1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'd255, 256, 1'b0, 259, 256, 256, 0,  1'b0};
        vecs[5] = '{1'b0, 8'h42, 8'd1,   0,   1'b0, 5,   2,   2,   2,  1'b1};

        do_reset();
        check("reset busy", 32'(busy), 32'd0);
        check("reset grant", 32'(grant), 32'd0);
        check("reset err_wlast", 32'(err_wlast), 32'd0);
        check("reset s valids", 32'({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.wlast}), 32'd0);
        check("reset s payload", s_if.awaddr | s_if.wdata, 32'd0);
        check("reset m ready/valid", 32'({m0_if.awready, m0_if.wready, m0_if.bvalid,
                                         m1_if.awready, m1_if.wready, m1_if.bvalid}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_txn(vecs[i].mst, vecs[i].id, vecs[i].len, vecs[i].wlast_beat, vecs[i].toggle,
                    r_cycles, r_beats, r_wlast_pos, r_err_beat, r_pay_ok, r_iso_ok,
                    r_grant, r_bid, r_bresp, r_timeout);
            check($sformatf("v%0d timeout", i), 32'(r_timeout), 32'd0);
            check($sformatf("v%0d cycles", i), r_cycles, vecs[i].exp_cycles);
            check($sformatf("v%0d beats", i), r_beats, vecs[i].exp_beats);
            check($sformatf("v%0d wlast_pos", i), r_wlast_pos, vecs[i].exp_wlast_pos);
            check($sformatf("v%0d err_beat", i), r_err_beat, vecs[i].exp_err_beat);
            check($sformatf("v%0d err_wlast", i), 32'(err_wlast), 32'(vecs[i].exp_err));
            check($sformatf("v%0d payload", i), 32'(r_pay_ok), 32'd1);
            check($sformatf("v%0d isolation", i), 32'(r_iso_ok), 32'd1);
            check($sformatf("v%0d grant", i), 32'(r_grant), 32'(vecs[i].mst));
            check($sformatf("v%0d bid", i), 32'(r_bid), 32'(vecs[i].id));
            check($sformatf("v%0d bresp", i), 32'(r_bresp), 32'(vecs[i].id[1:0]));
            check($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
        end

        // Simultaneous requests after reset: m0 first, m1 right after m0's B.
        do_reset();
        drive_aw(1'b1, 1'b1, 8'h21, 8'd1);
        run_txn(1'b0, 8'h20, 8'd1, 2, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("tie first grant", 32'(r_grant), 32'd0);
        check("tie first cycles", r_cycles, 32'd5);
        check("tie first isolation", 32'(r_iso_ok), 32'd1);
        run_txn(1'b1, 8'h21, 8'd1, 2, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("tie second grant", 32'(r_grant), 32'd1);
        check("tie second cycles", r_cycles, 32'd5);
        check("tie second bid", 32'(r_bid), 32'h21);

        // m0 keeps requesting while m1 waits: grants go m0, m1, m0.
        do_reset();
        run_txn(1'b0, 8'h30, 8'd0, 1, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("alt grant 1", 32'(r_grant), 32'd0);
        drive_aw(1'b0, 1'b1, 8'h31, 8'd0);
        run_txn(1'b1, 8'h32, 8'd0, 1, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("alt grant 2", 32'(r_grant), 32'd1);
        check("alt isolation 2", 32'(r_iso_ok), 32'd1);
        run_txn(1'b0, 8'h31, 8'd0, 1, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("alt grant 3", 32'(r_grant), 32'd0);
        check("alt cycles 3", r_cycles, 32'd4);

        // Reset pulsed during the second W beat of an m0 burst.
        do_reset();
        drive_aw(1'b0, 1'b1, 8'h50, 8'd5);
        drive_b(1'b0, 1'b1);
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        @(posedge aclk); #1;
        check("rst-mid s_awvalid in ADDR", 32'(s_if.awvalid), 32'd1);
        @(posedge aclk); #1;
        drive_aw(1'b0, 1'b0, 8'h50, 8'd5);
        drive_w(1'b0, 1'b1, 8'h50, 0, 1'b0);
        @(posedge aclk); #1;
        drive_w(1'b0, 1'b1, 8'h50, 1, 1'b0);
        check("rst-mid in DATA", 32'({busy, s_if.wvalid, m0_if.wready}), 32'b111);
        areset = 1'b1;
        @(posedge aclk); #1;
        check("rst-mid busy", 32'(busy), 32'd0);
        check("rst-mid s handshakes", 32'({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.wlast}), 32'd0);
        check("rst-mid m handshakes", 32'({m0_if.awready, m0_if.wready, m0_if.bvalid,
                                          m1_if.awready, m1_if.wready, m1_if.bvalid}), 32'd0);
        check("rst-mid grant/err", 32'({grant, err_wlast}), 32'd0);
        areset = 1'b0;
        clear_inputs();
        @(posedge aclk); #1;
        run_txn(1'b1, 8'h60, 8'd2, 3, 1'b0, r_cycles, r_beats, r_wlast_pos, r_err_beat,
                r_pay_ok, r_iso_ok, r_grant, r_bid, r_bresp, r_timeout);
        check("post-rst grant", 32'(r_grant), 32'd1);
        check("post-rst cycles", r_cycles, 32'd6);
        check("post-rst beats", r_beats, 32'd3);
        check("post-rst payload", 32'(r_pay_ok), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
